dot_product_seq: RTL and testbench
==================================

Name: dot_product_seq

Overview:
- Sequencer wrapped around the 8x8 shift-add multiplier, which has start/ready ports and a 16-bit product.
- Upstream: accepts a stream of (a,b) operand pairs through a valid/ready handshake.
- Per pair: launches the multiplier, waits for its ready, and accumulates the 16-bit product.
- On the element flagged last, presents the dot-product sum downstream with a valid/ready handshake.

Parameters:
- ACC_W, 24, accumulator and out_sum width; must be at least 16.
- LEN_W, 4, element-counter width; maximum vector length is 2^LEN_W-1.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  operand pair valid
- in_ready  output  1  sequencer can accept a pair
- in_a  input  8  operand a (unsigned)
- in_b  input  8  operand b (unsigned)
- in_last  input  1  pair is the final element of the vector
- mul_start  output  1  one-cycle launch pulse to the multiplier
- mul_a  output  8  multiplicand to the multiplier
- mul_b  output  8  multiplier operand to the multiplier
- mul_product  input  16  multiplier product
- mul_ready  input  1  multiplier done flag, level, high while idle
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- out_sum  output  ACC_W  accumulated sum
- out_len  output  LEN_W  number of elements accumulated
- out_ovf  output  1  sticky: carry out of ACC_W occurred during this vector
- out_trunc  output  1  vector was force-terminated at max length

Behaviour:
- States: FETCH, ISSUE, WAIT, DONE.
- Reset, synchronous and dominant over all else:
  - state=FETCH; acc, count, ovf, trunc = 0.
  - mul_start=0, out_valid=0, operand regs=0.
  - in_ready=1 from the first cycle after reset deasserts.
- Reset mid-operation:
  - The multiplier is not reset and may still be iterating; mul_ready is ignored.
  - The next mul_start restarts the multiplier cleanly.
- mul_ready is never sampled before this block has issued a mul_start; the multiplier's counter is unknown from power-up.
- FETCH:
  - in_ready=1.
  - On in_valid&&in_ready: capture in_a, in_b, in_last into registers and go to ISSUE.
- ISSUE:
  - mul_start=1 for exactly one cycle, then go to WAIT.
  - mul_a/mul_b are driven from the registered operands at all times and are stable through ISSUE and WAIT.
- WAIT:
  - mul_ready is low from the first WAIT cycle; the multiplier clears its counter on the start edge.
  - When mul_ready=1, on the same edge:
    - acc <= acc + zero-extended mul_product;
    - ovf |= carry out of bit ACC_W-1;
    - count <= count+1.
  - Next state is DONE if last_reg is set, or if count+1 = 2^LEN_W-1 (which also sets trunc=1); otherwise FETCH.
- Timing:
  - With the standard 8-iteration multiplier, WAIT lasts 9 cycles: 8 with mul_ready low, plus the sampling cycle.
  - Element throughput is 11 cycles: handshake, ISSUE, 9 x WAIT.
- Arithmetic:
  - Accumulation wraps modulo 2^ACC_W.
  - ovf is sticky until the result is consumed.
- DONE:
  - out_valid=1; out_sum=acc, out_len=count, out_ovf=ovf, out_trunc=trunc, all held stable until out_valid&&out_ready.
  - in_ready=0.
  - On handshake: clear acc, count, ovf, trunc and go to FETCH; in_ready=1 the next cycle.
- in_ready is 0 in ISSUE, WAIT and DONE; there is no operand buffering.
- in_valid without in_ready has no effect; the source must hold its data.
- out_ready asserted outside DONE is ignored.
- Single-element vector (in_last on the first pair): out_len=1, out_sum = a*b.

Test Plan:
- Reset, then pairs (3,4),(5,6),(7,8,last) with a behavioural shift-add multiplier model -> out_sum=98, out_len=3, out_ovf=0; each element takes 11 cycles; mul_start pulses exactly 3 times, each 1 cycle wide.
- Single pair (255,255,last) -> out_sum=65025, out_len=1; out_valid asserts 10 cycles after the input handshake cycle.
- ACC_W=16 override, pairs (255,255),(255,255,last) -> out_sum=(130050 mod 65536)=64514, out_ovf=1; the following vector (1,1,last) -> out_sum=1, out_ovf=0.
- 15 pairs of (1,2) with in_last never set (LEN_W=4) -> DONE after the 15th, out_sum=30, out_len=15, out_trunc=1; in_ready stays 0 until consumed.
- Hold out_ready=0 for 20 cycles in DONE -> out_valid and out_sum stable, in_ready=0, no mul_start; out_ready=1 -> handshake, then in_ready=1 next cycle with acc cleared.
- Assert reset during WAIT of the 2nd element -> next cycle state FETCH, out_valid=0, mul_start=0; a new vector (2,3,last) -> out_sum=6, out_len=1, with no contamination from the aborted vector.

Source files
------------

// File: rtl/dot_product_seq_if.sv
// Operand-stream, multiplier-port and result-stream bundle for the dot-product sequencer.
// Latency: none; wires only.
// Backpressure: in_valid/in_ready and out_valid/out_ready handshakes; mul_start/mul_ready launch-and-wait.
interface dot_product_seq_if #(
  parameter int ACC_W = 24,
  parameter int LEN_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_a;
  logic [7:0]       in_b;
  logic             in_last;
  logic             mul_start;
  logic [7:0]       mul_a;
  logic [7:0]       mul_b;
  logic [15:0]      mul_product;
  logic             mul_ready;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic [LEN_W-1:0] out_len;
  logic             out_ovf;
  logic             out_trunc;

  // Sequencer side
  modport slave (
    input  in_valid, in_a, in_b, in_last, mul_product, mul_ready, out_ready,
    output in_ready, mul_start, mul_a, mul_b, out_valid, out_sum, out_len, out_ovf, out_trunc
  );

  // Environment side: operand source, multiplier and result sink
  modport master (
    output in_valid, in_a, in_b, in_last, mul_product, mul_ready, out_ready,
    input  in_ready, mul_start, mul_a, mul_b, out_valid, out_sum, out_len, out_ovf, out_trunc
  );
endinterface

// File: rtl/dot_product_seq.sv
// Dot-product sequencer: feeds (a,b) pairs to an external shift-add multiplier and accumulates the products.
// Latency: 11 cycles per element (handshake, ISSUE, 9 x WAIT); result valid 10 edges after the last input handshake.
// Backpressure: one pair in flight, in_ready low outside FETCH; result held in DONE until out_ready.
module dot_product_seq #(
  parameter int ACC_W = 24,
  parameter int LEN_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  dot_product_seq_if.slave   bus
);

  typedef enum logic [1:0] {FETCH, ISSUE, WAIT, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [7:0]       a_reg;
  logic [7:0]       b_reg;
  logic             last_reg;
  logic [ACC_W-1:0] acc;
  logic [LEN_W-1:0] count;
  logic             ovf;
  logic             trunc;

  logic [ACC_W:0]   acc_sum;
  logic [LEN_W-1:0] count_inc;
  logic             at_max;
  logic             in_rdy;
  logic             start;
  logic             res_vld;
  logic             take;
  logic             mul_done;
  logic             res_taken;

  // Extra top bit of the sum is the carry out of the accumulator.
  assign acc_sum   = {1'b0, acc} + (ACC_W+1)'(bus.mul_product);
  assign count_inc = count + LEN_W'(1);
  // Counter would reach its all-ones value: the vector is force-terminated there.
  assign at_max    = (count_inc == {LEN_W{1'b1}});

  assign take      = bus.in_valid && in_rdy;
  // mul_ready is only looked at in WAIT, i.e. always after our own mul_start.
  assign mul_done  = (state == WAIT) && bus.mul_ready;
  assign res_taken = res_vld && bus.out_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= state_nxt;
  end

  // Next-state and handshake outputs; reset forces all handshakes inactive.
  always_comb begin
    state_nxt = state;
    in_rdy    = 1'b0;
    start     = 1'b0;
    res_vld   = 1'b0;
    case (state)
      FETCH: begin
        in_rdy = !reset;
        if (bus.in_valid) state_nxt = ISSUE;
      end
      ISSUE: begin
        start     = !reset;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (bus.mul_ready) state_nxt = (last_reg || at_max) ? DONE : FETCH;
      end
      DONE: begin
        res_vld = !reset;
        if (bus.out_ready) state_nxt = FETCH;
      end
      default: state_nxt = FETCH;
    endcase
  end

  // Operand capture, accumulation and per-vector status; cleared when the result is taken.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_reg    <= '0;
      b_reg    <= '0;
      last_reg <= 1'b0;
      acc      <= '0;
      count    <= '0;
      ovf      <= 1'b0;
      trunc    <= 1'b0;
    end else begin
      if (take) begin
        a_reg    <= bus.in_a;
        b_reg    <= bus.in_b;
        last_reg <= bus.in_last;
      end
      if (mul_done) begin
        acc   <= acc_sum[ACC_W-1:0];
        ovf   <= ovf | acc_sum[ACC_W];
        count <= count_inc;
        if (at_max) trunc <= 1'b1;
      end
      if (res_taken) begin
        acc   <= '0;
        count <= '0;
        ovf   <= 1'b0;
        trunc <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = in_rdy;
  assign bus.mul_start = start;
  assign bus.mul_a     = a_reg;
  assign bus.mul_b     = b_reg;
  assign bus.out_valid = res_vld;
  assign bus.out_sum   = acc;
  assign bus.out_len   = count;
  assign bus.out_ovf   = ovf;
  assign bus.out_trunc = trunc;

endmodule

// File: tb/tb_dot_product_seq.sv
// Bench for dot_product_seq: two instances (ACC_W=24 and ACC_W=16), each with a behavioural 8-step shift-add multiplier.
// Latency: checked against handshake cycle numbers.
// Backpressure: source holds data until in_ready; sink holds out_ready low to stall DONE.
module tb_dot_product_seq;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  dot_product_seq_if #(.ACC_W(24), .LEN_W(4)) bus24 ();
  dot_product_seq_if #(.ACC_W(16), .LEN_W(4)) bus16 ();

  dot_product_seq #(.ACC_W(24), .LEN_W(4)) dut24 (.clk(clk), .reset(reset), .bus(bus24));
  dot_product_seq #(.ACC_W(16), .LEN_W(4)) dut16 (.clk(clk), .reset(reset), .bus(bus16));

  // Shift-add multiplier models: never reset, counter starts mid-count to mimic power-up junk.
  logic [3:0]  m24_cnt = 4'd5;
  logic [15:0] m24_mc  = 16'd0;
  logic [7:0]  m24_mp  = 8'd0;
  logic [15:0] m24_p   = 16'd0;
  always @(posedge clk) begin
    if (bus24.mul_start) begin
      m24_cnt <= 4'd8; m24_mc <= {8'd0, bus24.mul_a}; m24_mp <= bus24.mul_b; m24_p <= 16'd0;
    end else if (m24_cnt != 4'd0) begin
      if (m24_mp[0]) m24_p <= m24_p + m24_mc;
      m24_mc <= m24_mc << 1; m24_mp <= m24_mp >> 1; m24_cnt <= m24_cnt - 4'd1;
    end
  end
  assign bus24.mul_ready   = (m24_cnt == 4'd0);
  assign bus24.mul_product = m24_p;

  logic [3:0]  m16_cnt = 4'd3;
  logic [15:0] m16_mc  = 16'd0;
  logic [7:0]  m16_mp  = 8'd0;
  logic [15:0] m16_p   = 16'd0;
  always @(posedge clk) begin
    if (bus16.mul_start) begin
      m16_cnt <= 4'd8; m16_mc <= {8'd0, bus16.mul_a}; m16_mp <= bus16.mul_b; m16_p <= 16'd0;
    end else if (m16_cnt != 4'd0) begin
      if (m16_mp[0]) m16_p <= m16_p + m16_mc;
      m16_mc <= m16_mc << 1; m16_mp <= m16_mp >> 1; m16_cnt <= m16_cnt - 4'd1;
    end
  end
  assign bus16.mul_ready   = (m16_cnt == 4'd0);
  assign bus16.mul_product = m16_p;

  // Count mul_start pulses and any pulse lasting more than one cycle.
  int   starts24 = 0;
  int   wide24   = 0;
  logic prev24   = 1'b0;
  always @(negedge clk) begin
    if (bus24.mul_start) begin
      starts24 <= starts24 + 1;
      if (prev24) wide24 <= wide24 + 1;
    end
    prev24 <= bus24.mul_start;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  int hs24, dn24, hs16;

  // All drive tasks are entered and left on a negedge.
  task automatic send24(input logic [7:0] a, input logic [7:0] b, input logic last);
    int n;
    n = 0;
    bus24.in_a = a; bus24.in_b = b; bus24.in_last = last; bus24.in_valid = 1'b1;
    while (bus24.in_ready !== 1'b1 && n < 300) begin @(negedge clk); n++; end
    if (n >= 300) chk("send24_timeout", {31'd0, bus24.in_ready}, 32'd1);
    hs24 = cyc;
    @(negedge clk);
    bus24.in_valid = 1'b0;
  endtask

  task automatic wait24();
    int n;
    n = 0;
    while (bus24.out_valid !== 1'b1 && n < 300) begin @(negedge clk); n++; end
    if (n >= 300) chk("wait24_timeout", {31'd0, bus24.out_valid}, 32'd1);
    dn24 = cyc;
  endtask

  task automatic ack24();
    bus24.out_ready = 1'b1;
    @(negedge clk);
    bus24.out_ready = 1'b0;
  endtask

  task automatic send16(input logic [7:0] a, input logic [7:0] b, input logic last);
    int n;
    n = 0;
    bus16.in_a = a; bus16.in_b = b; bus16.in_last = last; bus16.in_valid = 1'b1;
    while (bus16.in_ready !== 1'b1 && n < 300) begin @(negedge clk); n++; end
    if (n >= 300) chk("send16_timeout", {31'd0, bus16.in_ready}, 32'd1);
    hs16 = cyc;
    @(negedge clk);
    bus16.in_valid = 1'b0;
  endtask

  task automatic wait16();
    int n;
    n = 0;
    while (bus16.out_valid !== 1'b1 && n < 300) begin @(negedge clk); n++; end
    if (n >= 300) chk("wait16_timeout", {31'd0, bus16.out_valid}, 32'd1);
  endtask

  task automatic ack16();
    bus16.out_ready = 1'b1;
    @(negedge clk);
    bus16.out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int h1, h2, h3, s0, hb, rb;
    logic [23:0] held;
    bus24.in_valid = 0; bus24.in_a = 0; bus24.in_b = 0; bus24.in_last = 0; bus24.out_ready = 0;
    bus16.in_valid = 0; bus16.in_a = 0; bus16.in_b = 0; bus16.in_last = 0; bus16.out_ready = 0;

    // Reset state
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", {31'd0, bus24.in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, bus24.out_valid}, 32'd0);
    chk("rst_mul_start", {31'd0, bus24.mul_start}, 32'd0);
    chk("rst_out_sum", bus24.out_sum, 32'd0);
    chk("rst_out_len", bus24.out_len, 32'd0);

    // 3*4 + 5*6 + 7*8 = 98
    s0 = starts24;
    send24(8'd3, 8'd4, 1'b0); h1 = hs24;
    send24(8'd5, 8'd6, 1'b0); h2 = hs24;
    send24(8'd7, 8'd8, 1'b1); h3 = hs24;
    chk("issue_mul_start", {31'd0, bus24.mul_start}, 32'd1);
    chk("issue_mul_a", bus24.mul_a, 32'd7);
    chk("issue_mul_b", bus24.mul_b, 32'd8);
    @(negedge clk);
    chk("wait_in_ready", {31'd0, bus24.in_ready}, 32'd0);
    chk("wait_mul_a", bus24.mul_a, 32'd7);
    wait24();
    chk("v1_sum", bus24.out_sum, 32'd98);
    chk("v1_len", bus24.out_len, 32'd3);
    chk("v1_ovf", {31'd0, bus24.out_ovf}, 32'd0);
    chk("v1_trunc", {31'd0, bus24.out_trunc}, 32'd0);
    chk("v1_period_1_2", h2 - h1, 32'd11);
    chk("v1_period_2_3", h3 - h2, 32'd11);
    // DONE window is h3+11; counted from the handshake edge that is 10 edges.
    chk("v1_latency", dn24 - h3 - 1, 32'd10);
    chk("v1_start_count", starts24 - s0, 32'd3);
    ack24();
    chk("v1_post_in_ready", {31'd0, bus24.in_ready}, 32'd1);
    chk("v1_post_out_valid", {31'd0, bus24.out_valid}, 32'd0);

    // Single element 255*255, then a stall of 20 cycles in DONE with junk offered upstream
    send24(8'd255, 8'd255, 1'b1); h1 = hs24;
    wait24();
    chk("v2_sum", bus24.out_sum, 32'd65025);
    chk("v2_len", bus24.out_len, 32'd1);
    chk("v2_latency", dn24 - h1 - 1, 32'd10);
    held = 24'd65025;
    bus24.in_a = 8'd9; bus24.in_b = 8'd9; bus24.in_last = 1'b1; bus24.in_valid = 1'b1;
    hb = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus24.out_valid !== 1'b1 || bus24.out_sum !== held || bus24.in_ready !== 1'b0 ||
          bus24.mul_start !== 1'b0) hb++;
    end
    chk("hold_stable_cycles_bad", hb, 32'd0);
    bus24.in_valid = 1'b0;
    ack24();
    chk("v2_post_in_ready", {31'd0, bus24.in_ready}, 32'd1);
    chk("v2_post_out_valid", {31'd0, bus24.out_valid}, 32'd0);

    // 15 x (1,2) without last: forced termination, sum 30
    for (int i = 0; i < 15; i++) send24(8'd1, 8'd2, 1'b0);
    wait24();
    chk("trunc_sum", bus24.out_sum, 32'd30);
    chk("trunc_len", bus24.out_len, 32'd15);
    chk("trunc_flag", {31'd0, bus24.out_trunc}, 32'd1);
    chk("trunc_ovf", {31'd0, bus24.out_ovf}, 32'd0);
    bus24.in_a = 8'd1; bus24.in_b = 8'd2; bus24.in_last = 1'b0; bus24.in_valid = 1'b1;
    rb = 0;
    repeat (3) begin @(negedge clk); if (bus24.in_ready !== 1'b0) rb++; end
    chk("trunc_in_ready_held_low", rb, 32'd0);
    bus24.in_valid = 1'b0;
    ack24();
    // Status and accumulator must have been cleared by the handshake
    send24(8'd4, 8'd5, 1'b1);
    wait24();
    chk("after_trunc_sum", bus24.out_sum, 32'd20);
    chk("after_trunc_len", bus24.out_len, 32'd1);
    chk("after_trunc_flag", {31'd0, bus24.out_trunc}, 32'd0);
    ack24();

    // Reset while waiting on the 2nd element's product
    send24(8'd10, 8'd10, 1'b0);
    send24(8'd20, 8'd20, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", {31'd0, bus24.out_valid}, 32'd0);
    chk("midrst_mul_start", {31'd0, bus24.mul_start}, 32'd0);
    reset = 1'b0;
    #1;
    chk("midrst_in_ready", {31'd0, bus24.in_ready}, 32'd1);
    @(negedge clk);
    send24(8'd2, 8'd3, 1'b1);
    wait24();
    chk("midrst_sum", bus24.out_sum, 32'd6);
    chk("midrst_len", bus24.out_len, 32'd1);
    chk("midrst_ovf", {31'd0, bus24.out_ovf}, 32'd0);
    ack24();

    // 16-bit accumulator: 2 x 65025 = 130050 wraps to 64514 with carry
    send16(8'd255, 8'd255, 1'b0);
    send16(8'd255, 8'd255, 1'b1);
    wait16();
    chk("acc16_sum", bus16.out_sum, 32'd64514);
    chk("acc16_ovf", {31'd0, bus16.out_ovf}, 32'd1);
    chk("acc16_len", bus16.out_len, 32'd2);
    ack16();
    send16(8'd1, 8'd1, 1'b1);
    wait16();
    chk("acc16_next_sum", bus16.out_sum, 32'd1);
    chk("acc16_next_ovf", {31'd0, bus16.out_ovf}, 32'd0);
    ack16();

    @(negedge clk);
    chk("mul_start_wide_pulses", wide24, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
